stress_vote_window: RTL and testbench

- Downstream of the SVM classification PE; consumes its per-sample result (sample_classification, qualified by the one-cycle classify_sample_done pulse).
- Keeps a sliding window of the last WIN_LEN binary classifications and counts the positives.
- Produces a debounced stress decision using a majority threshold with hysteresis. This decision goes to the system-level stress output and interrupt logic.

---
 rtl/stress_vote_window.sv | 114 +++++++++++
 tb/tb_stress_vote_window.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stress_vote_window.sv
// Sliding-window majority vote over SVM classifications with hysteresis.
// Each accepted sample is evaluated one edge after it updates the window counts.
module stress_vote_window #(
   parameter int WIN_LEN = 8,
   parameter int THRESH  = 5,
   parameter int RELEASE = 3,
   parameter int CW      = 7
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          sample_classification,
   input  logic          classify_sample_done,
   input  logic          clear,
   output logic          stress_flag,
   output logic          stress_onset,
   output logic          vote_valid,
   output logic [CW-1:0] ones_count,
   output logic [CW-1:0] fill_count,
   output logic          window_full
);

   // state   | meaning
   // FILL_ST | window not yet full, accepted samples are not voted on
   // RUN_ST  | window full, every accepted sample produces a vote
   typedef enum logic {FILL_ST, RUN_ST} state_t;

   localparam logic [CW-1:0] WIN_CNT  = CW'(WIN_LEN);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIN_LEN - 1);
   localparam logic [CW-1:0] THR_CNT  = CW'(THRESH);
   localparam logic [CW-1:0] REL_CNT  = CW'(RELEASE);

   state_t               state_q, state_d;
   logic [WIN_LEN-1:0]   window_q, window_d;
   logic [CW-1:0]        ones_q, ones_d;
   logic [CW-1:0]        fill_q, fill_d;
   logic                 pend_q, pend_d;
   logic                 flag_q, flag_d;
   logic                 onset_q, onset_d;
   logic                 vote_q, vote_d;
   logic [CW-1:0]        new_bit, old_bit;

   assign new_bit = {{(CW-1){1'b0}}, sample_classification};
   assign old_bit = {{(CW-1){1'b0}}, window_q[WIN_LEN-1]};

   always_comb begin
      state_d  = state_q;
      window_d = window_q;
      ones_d   = ones_q;
      fill_d   = fill_q;
      flag_d   = flag_q;
      pend_d   = 1'b0;
      onset_d  = 1'b0;
      vote_d   = 1'b0;
      if (clear) begin
         state_d  = FILL_ST;
         window_d = '0;
         ones_d   = '0;
         fill_d   = '0;
         flag_d   = 1'b0;
      end else begin
         // ones_q already reflects the pending sample; a newer sample may update it this same edge
         if (pend_q && (state_q == RUN_ST)) begin
            vote_d = 1'b1;
            if (!flag_q && (ones_q >= THR_CNT)) begin
               flag_d  = 1'b1;
               onset_d = 1'b1;
            end else if (flag_q && (ones_q <= REL_CNT)) begin
               flag_d = 1'b0;
            end
         end
         if (classify_sample_done) begin
            window_d = {window_q[WIN_LEN-2:0], sample_classification};
            pend_d   = 1'b1;
            if (fill_q == WIN_CNT) begin
               ones_d = ones_q + new_bit - old_bit;
            end else begin
               ones_d = ones_q + new_bit;
               fill_d = fill_q + 1'b1;
               if (fill_q == LAST_CNT) state_d = RUN_ST;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= FILL_ST;
         window_q <= '0;
         ones_q   <= '0;
         fill_q   <= '0;
         pend_q   <= 1'b0;
         flag_q   <= 1'b0;
         onset_q  <= 1'b0;
         vote_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         window_q <= window_d;
         ones_q   <= ones_d;
         fill_q   <= fill_d;
         pend_q   <= pend_d;
         flag_q   <= flag_d;
         onset_q  <= onset_d;
         vote_q   <= vote_d;
      end
   end

   assign stress_flag  = flag_q;
   assign stress_onset = onset_q;
   assign vote_valid   = vote_q;
   assign ones_count   = ones_q;
   assign fill_count   = fill_q;
   assign window_full  = (fill_q == WIN_CNT);

endmodule

// File: tb/tb_stress_vote_window.sv
// Bench for stress_vote_window: queue-based window model feeding a vote scoreboard.
module tb_stress_vote_window;
   localparam int WIN_LEN = 8;
   localparam int THRESH  = 5;
   localparam int RELEASE = 3;
   localparam int CW      = 7;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          sample_classification;
   logic          classify_sample_done;
   logic          clear;
   logic          stress_flag, stress_onset, vote_valid, window_full;
   logic [CW-1:0] ones_count, fill_count;

   stress_vote_window #(.WIN_LEN(WIN_LEN), .THRESH(THRESH), .RELEASE(RELEASE), .CW(CW)) dut (
      .CLK(CLK), .RESET(RESET),
      .sample_classification(sample_classification),
      .classify_sample_done(classify_sample_done),
      .clear(clear),
      .stress_flag(stress_flag), .stress_onset(stress_onset), .vote_valid(vote_valid),
      .ones_count(ones_count), .fill_count(fill_count), .window_full(window_full)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit flag;
      bit onset;
   } exp_t;

   exp_t exp_q[$];
   bit   win_q[$];
   bit   m_flag;
   bit   last_pushed;
   int   n_pass = 0;
   int   n_total = 0;

   function automatic void chk(string nm, int act, int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
   endfunction

   function automatic int model_ones();
      int s = 0;
      foreach (win_q[i]) s += win_q[i];
      return s;
   endfunction

   function automatic void model_flush();
      win_q.delete();
      m_flag      = 1'b0;
      last_pushed = 1'b0;
   endfunction

   // Vote scoreboard: every vote_valid pops one expectation
   always @(negedge CLK) begin
      if (RESET !== 1'b1) begin
         if (vote_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_vote", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("vote_flag", int'(stress_flag), int'(e.flag));
               chk("vote_onset", int'(stress_onset), int'(e.onset));
            end
         end else if (stress_onset) begin
            chk("onset_without_vote", 1, 0);
         end
      end
   end

   task automatic step(input bit d, input bit c, input bit cl);
      classify_sample_done  = d;
      sample_classification = c;
      clear                 = cl;
      @(posedge CLK);
      #1;
      classify_sample_done  = 1'b0;
      sample_classification = $urandom_range(0, 1);
      clear                 = 1'b0;
      if (cl) begin
         // the vote of the sample accepted one edge earlier is cancelled
         if (last_pushed && exp_q.size() > 0) void'(exp_q.pop_back());
         model_flush();
      end else if (d) begin
         win_q.push_front(c);
         if (win_q.size() > WIN_LEN) void'(win_q.pop_back());
         last_pushed = 1'b0;
         if (win_q.size() == WIN_LEN) begin
            exp_t e;
            int   o;
            o       = model_ones();
            e.onset = 1'b0;
            if (!m_flag && o >= THRESH) begin
               m_flag  = 1'b1;
               e.onset = 1'b1;
            end else if (m_flag && o <= RELEASE) begin
               m_flag = 1'b0;
            end
            e.flag = m_flag;
            exp_q.push_back(e);
            last_pushed = 1'b1;
         end
      end else begin
         last_pushed = 1'b0;
      end
      chk("ones_count", int'(ones_count), model_ones());
      chk("fill_count", int'(fill_count), win_q.size());
      chk("window_full", int'(window_full), int'(win_q.size() == WIN_LEN));
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_flag"},  int'(stress_flag),  0);
      chk({nm, "_onset"}, int'(stress_onset), 0);
      chk({nm, "_vote"},  int'(vote_valid),   0);
      chk({nm, "_ones"},  int'(ones_count),   0);
      chk({nm, "_fill"},  int'(fill_count),   0);
      chk({nm, "_full"},  int'(window_full),  0);
   endtask

   initial begin
      int bias;
      RESET = 1'b1;
      classify_sample_done  = 1'b0;
      sample_classification = 1'b1;
      clear = 1'b0;
      model_flush();
      repeat (3) @(posedge CLK);
      #1;
      check_all_zero("in_reset");
      RESET = 1'b0;
      repeat (10) step(0, 0, 0);
      check_all_zero("idle");

      // fill with ones: first vote on the 8th sample, raising the flag
      repeat (7) step(1, 1, 0);
      chk("flag_during_fill", int'(stress_flag), 0);
      step(1, 1, 0);
      repeat (3) step(0, 0, 0);
      chk("flag_after_fill", int'(stress_flag), 1);

      // zeros drain it through the hysteresis band, then ones refill it
      repeat (6) step(1, 0, 0);
      chk("flag_released", int'(stress_flag), 0);
      repeat (6) step(1, 1, 0);
      step(0, 0, 0);
      chk("flag_reasserted", int'(stress_flag), 1);

      // alternating pattern from empty window
      step(0, 0, 1);
      for (int i = 0; i < 20; i++) step(1, (i % 2 == 0), 0);
      step(0, 0, 0);
      chk("alt_flag", int'(stress_flag), 0);

      // full window of zeros then back-to-back 1,1,0
      step(0, 0, 1);
      repeat (8) step(1, 0, 0);
      step(1, 1, 0);
      step(1, 1, 0);
      step(1, 0, 0);
      repeat (2) step(0, 0, 0);

      // clear colliding with a done while stressed
      repeat (8) step(1, 1, 0);
      repeat (2) step(0, 0, 0);
      chk("pre_clear_flag", int'(stress_flag), 1);
      step(1, 1, 1);
      check_all_zero("after_clear");
      step(0, 0, 0);

      // clear cancelling a pending evaluation
      repeat (8) step(1, 1, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      chk("cancel_flag", int'(stress_flag), 0);

      // async reset mid-fill
      repeat (4) step(1, 1, 0);
      #2;
      RESET = 1'b1;
      #1;
      check_all_zero("mid_fill_reset");
      exp_q.delete();
      model_flush();
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      step(0, 0, 0);

      // randomized traffic with drifting bias to cross both thresholds
      bias = 50;
      for (int i = 0; i < 1500; i++) begin
         if (i % 40 == 0) bias = $urandom_range(0, 100);
         step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < bias,
              $urandom_range(0, 199) == 0);
      end

      repeat (4) step(0, 0, 0);
      chk("votes_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
